// File: rtl/pc_fetch_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_pkg
//   Shared definitions for the instruction-fetch slice: word width, reset PC
//   default, PC increment, fetch FSM states and the instruction-buffer entry
//   layout. Imported by the interface, the FIFO and the fetch top.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package pc_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } ibuf_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_if
//   Bundles the fetch unit's handshake channels:
//     imem request  : imem_req_valid/ready, imem_req_addr
//     imem response : imem_rsp_valid, imem_rsp_data
//     decode side   : inst_valid/ready, inst, inst_pc, inst_pc4
//     redirect      : redirect_valid, redirect_pc
//   master = fetch unit view, slave = memory/decode/branch-resolution view.
// ---------------------------------------------------------------------------
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_pc4;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc, inst_pc4,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc, inst_pc4,
        output inst_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/pc_fetch_sync_fifo.sv
// ---------------------------------------------------------------------------
// pc_fetch_sync_fifo
//   Single-clock FIFO with synchronous clear and a combinational head read.
//   Ports:
//     clk, rst_n  clock and synchronous active-low reset
//     clear       drop all entries (wins over push/pop in the same cycle)
//     push        write push_data (ignored when full unless popping too)
//     pop         drop head entry (ignored when empty)
//     pop_data    current head entry (undefined contents while empty)
//     count       number of stored entries
// ---------------------------------------------------------------------------
module pc_fetch_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO may still accept a word when its head leaves at the same edge.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // The owner's credit accounting must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
//   Owns the architectural fetch PC. Issues in-order word fetches to
//   instruction memory, tracks in-flight request PCs, buffers returned words
//   and hands {inst, pc, pc+4} to decode. A redirect flushes buffered words
//   and marks every in-flight request as killed so its response is dropped.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    pc_fetch_if.master (imem request/response, decode, redirect)
// ---------------------------------------------------------------------------
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2,
    parameter int unsigned     MAX_OUT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_if.master bus
);

    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned BUF_W = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0] kill_q, kill_d;

    logic [OUT_W-1:0] pcq_count;      // accepted-but-unanswered requests
    logic [XLEN-1:0]  rsp_pc;
    logic [BUF_W-1:0] buf_count;
    ibuf_entry_t      rsp_entry;
    ibuf_entry_t      head;

    logic             req_valid, req_fire;
    logic             rsp_fire, rsp_live, inst_fire, ibuf_valid;
    logic [OUT_W-1:0] outstanding_next;
    logic [31:0]      credit_used;

    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp_fire   = bus.imem_rsp_valid && (pcq_count != '0);
    assign rsp_live   = rsp_fire && (kill_q == '0);
    assign ibuf_valid = (buf_count != '0);
    assign inst_fire  = ibuf_valid && bus.inst_ready;

    // Slots claimed by buffered words plus live (not killed) requests. A word
    // decode takes at this edge frees its slot at the same edge, which is what
    // lets a 1-cycle memory sustain one instruction per cycle with DEPTH=2.
    assign credit_used = 32'(buf_count) + 32'(pcq_count) - 32'(kill_q) - 32'(inst_fire);

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        kill_d           = kill_q;
        req_valid        = 1'b0;
        req_fire         = 1'b0;
        outstanding_next = pcq_count;

        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  req_valid = (credit_used < DEPTH)
                              && (32'(pcq_count) < MAX_OUT)
                              && !bus.redirect_valid;
        endcase

        req_fire         = req_valid && bus.imem_req_ready;
        outstanding_next = pcq_count + OUT_W'(req_fire) - OUT_W'(rsp_fire);

        if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (rsp_fire && (kill_q != '0)) kill_d = kill_q - OUT_W'(1);

        // Redirect is applied after this cycle's response bookkeeping, so the
        // kill count covers exactly the requests still in flight afterwards.
        if (bus.redirect_valid) begin
            fetch_pc_d = align_word(bus.redirect_pc);
            kill_d     = outstanding_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            kill_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
        end
    end

    // In-flight PC queue: one entry per accepted request, killed or not, so
    // every response can be paired with its address.
    pc_fetch_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_fire),
        .pop_data  (rsp_pc),
        .count     (pcq_count)
    );

    assign rsp_entry = '{inst: bus.imem_rsp_data, pc: rsp_pc};

    // Instruction buffer. Clearing on redirect wins over a same-cycle push, and
    // a same-cycle decode handshake still counts as delivered.
    pc_fetch_sync_fifo #(
        .WIDTH ($bits(ibuf_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.redirect_valid),
        .push      (rsp_live),
        .push_data (rsp_entry),
        .pop       (inst_fire),
        .pop_data  (head),
        .count     (buf_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = ibuf_valid;
    assign bus.inst           = ibuf_valid ? head.inst : '0;
    assign bus.inst_pc        = ibuf_valid ? head.pc : '0;
    assign bus.inst_pc4       = ibuf_valid ? (head.pc + PC_STEP) : '0;

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
//   Directed bench for pc_fetch (DEPTH=2, MAX_OUT=2, RESET_PC=0). A small
//   in-order memory model answers each accepted request one cycle later with
//   data = addr ^ 32'hA5A5A5A5 unless responses are held off. Inputs change
//   just after the rising edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    localparam logic [31:0] SCRAMBLE = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_fetch_if bus ();

    pc_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2),
        .MAX_OUT  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem_q [$];
    logic        mem_en;
    logic        stray;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    // Head of the decode channel must be the word fetched from pc.
    task automatic chk_inst(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
        check({tag, "_pc"},    bus.inst_pc,  pc);
        check({tag, "_pc4"},   bus.inst_pc4, pc + 32'd4);
        check({tag, "_inst"},  bus.inst,     pc ^ SCRAMBLE);
    endtask

    task automatic chk_req(input string tag, input logic valid, input logic [31:0] addr);
        check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'(valid));
        if (valid) check({tag, "_req_addr"}, bus.imem_req_addr, addr);
    endtask

    // Drive the response channel from the memory model, then wait for the
    // sampling point.
    task automatic to_sample();
        if (stray) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (mem_en && mem_q.size() != 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_q[0] ^ SCRAMBLE;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
    endtask

    // Record this cycle's handshakes, cross the rising edge, update the model.
    task automatic next_cycle();
        logic        req_fire;
        logic        rsp_fire;
        logic [31:0] addr;
        req_fire = bus.imem_req_valid && bus.imem_req_ready;
        addr     = bus.imem_req_addr;
        rsp_fire = bus.imem_rsp_valid && !stray;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_q.delete();
        end else begin
            if (rsp_fire) void'(mem_q.pop_front());
            if (req_fire) mem_q.push_back(addr);
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        mem_en             = 1'b1;
        stray              = 1'b0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            to_sample();
            check("rst_req_valid",  32'(bus.imem_req_valid), 32'd0);
            check("rst_inst_valid", 32'(bus.inst_valid),     32'd0);
            check("rst_inst_pc",    bus.inst_pc,             32'h0);
            next_cycle();
        end

        // BOOT: one cycle without requests.
        rst_n = 1'b1;
        to_sample();
        chk_req("boot", 1'b0, 32'h0);
        check("boot_inst_valid", 32'(bus.inst_valid), 32'd0);
        next_cycle();

        // Streaming with 1-cycle memory and decode always ready.
        bus.inst_ready = 1'b1;
        to_sample();
        chk_req("r0", 1'b1, 32'h0);
        check("r0_inst_valid", 32'(bus.inst_valid), 32'd0);
        next_cycle();
        to_sample();
        chk_req("r1", 1'b1, 32'h4);
        check("r1_inst_valid", 32'(bus.inst_valid), 32'd0);
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            to_sample();
            chk_inst("stream", 32'(4 * k));
            chk_req("stream", 1'b1, 32'(4 * k + 8));
            next_cycle();
        end

        // Decode stalls: 0x18 and 0x1C fill the buffer, then requests stop.
        bus.inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_sample();
            chk_inst("stall", 32'h18);
            chk_req("stall", 1'b0, 32'h0);
            next_cycle();
        end

        // Decode resumes while memory refuses requests for three cycles.
        bus.inst_ready     = 1'b1;
        bus.imem_req_ready = 1'b0;
        to_sample();
        chk_inst("drain0", 32'h18);
        chk_req("hold0", 1'b1, 32'h20);
        next_cycle();
        to_sample();
        chk_inst("drain1", 32'h1C);
        chk_req("hold1", 1'b1, 32'h20);
        next_cycle();
        to_sample();
        check("drain_empty", 32'(bus.inst_valid), 32'd0);
        chk_req("hold2", 1'b1, 32'h20);
        next_cycle();

        // Two requests go out with responses held off.
        bus.imem_req_ready = 1'b1;
        to_sample();
        chk_req("fill0", 1'b1, 32'h20);
        next_cycle();
        mem_en = 1'b0;
        to_sample();
        chk_req("fill1", 1'b1, 32'h24);
        next_cycle();

        // Redirect to 0x102 with both requests in flight.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0102;
        to_sample();
        chk_req("redir_cycle", 1'b0, 32'h0);
        check("redir_inst_valid", 32'(bus.inst_valid), 32'd0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        to_sample();
        chk_req("maxout", 1'b0, 32'h0);
        check("redir_addr", bus.imem_req_addr, 32'h100);
        next_cycle();
        mem_en = 1'b1;
        to_sample();
        chk_req("kill0", 1'b0, 32'h0);
        check("kill0_inst_valid", 32'(bus.inst_valid), 32'd0);
        next_cycle();
        to_sample();
        chk_req("kill1", 1'b1, 32'h100);
        check("kill1_inst_valid", 32'(bus.inst_valid), 32'd0);
        next_cycle();
        to_sample();
        chk_req("tgt_next", 1'b1, 32'h104);
        check("tgt_wait", 32'(bus.inst_valid), 32'd0);
        next_cycle();
        to_sample();
        chk_inst("tgt", 32'h100);
        chk_req("tgt", 1'b1, 32'h108);
        next_cycle();

        // Redirect while 0x104 is consumed: 0x104 delivered, 0x108 flushed.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0008;
        to_sample();
        chk_inst("rd_hs", 32'h104);
        chk_req("rd_hs", 1'b0, 32'h0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        to_sample();
        check("flush108", 32'(bus.inst_valid), 32'd0);
        chk_req("to8", 1'b1, 32'h8);
        next_cycle();
        to_sample();
        chk_req("toC", 1'b1, 32'hC);
        next_cycle();
        to_sample();
        chk_inst("buf8", 32'h8);
        chk_req("bufC", 1'b0, 32'h0);
        next_cycle();

        // Buffer holds {0x8, 0xC}; consume 0x8 during a redirect to 0x200.
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        to_sample();
        chk_inst("hs8", 32'h8);
        next_cycle();
        bus.redirect_valid = 1'b0;
        to_sample();
        check("flushC0", 32'(bus.inst_valid), 32'd0);
        chk_req("to200", 1'b1, 32'h200);
        next_cycle();
        to_sample();
        check("flushC1", 32'(bus.inst_valid), 32'd0);
        chk_req("to204", 1'b1, 32'h204);
        next_cycle();

        // Redirect to an unaligned address at the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        to_sample();
        chk_inst("at200", 32'h200);
        next_cycle();
        bus.redirect_valid = 1'b0;
        to_sample();
        chk_req("top", 1'b1, 32'hFFFF_FFFC);
        next_cycle();
        to_sample();
        chk_req("wrap", 1'b1, 32'h0);
        next_cycle();
        bus.imem_req_ready = 1'b0;
        to_sample();
        chk_inst("topi", 32'hFFFF_FFFC);
        check("wrap_pc4", bus.inst_pc4, 32'h0000_0000);
        next_cycle();
        to_sample();
        chk_inst("after_wrap", 32'h0);
        next_cycle();

        // Response with nothing outstanding must change nothing.
        stray = 1'b1;
        to_sample();
        check("stray_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk_req("stray", 1'b1, 32'h4);
        next_cycle();
        stray              = 1'b0;
        bus.imem_req_ready = 1'b1;
        to_sample();
        check("post_stray_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk_req("post_stray", 1'b1, 32'h4);
        next_cycle();
        to_sample();
        chk_req("post_stray_next", 1'b1, 32'h8);
        next_cycle();
        to_sample();
        chk_inst("post_stray", 32'h4);
        next_cycle();

        // Reset in the middle of streaming.
        rst_n = 1'b0;
        to_sample();
        next_cycle();
        rst_n = 1'b1;
        to_sample();
        chk_req("rst2_boot", 1'b0, 32'h0);
        check("rst2_inst_valid", 32'(bus.inst_valid), 32'd0);
        next_cycle();
        to_sample();
        chk_req("rst2_run", 1'b1, 32'h0);
        check("rst2_run_inst_valid", 32'(bus.inst_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
